// File: rtl/wb_trace_uart_if.sv
// Trace-port bundle between the MIPS write-back stage and the trace UART.
// The core side is the master; the trace unit is the slave.
interface wb_trace_uart_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [5:0]       P_C;
  logic             REG_WR;
  logic [4:0]       DIR_WRA;
  logic [31:0]      DI_banco;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic [7:0]       drop_count;

  modport master (
    output P_C, REG_WR, DIR_WRA, DI_banco,
    input  tx, busy, fifo_count, overflow, drop_count
  );

  modport slave (
    input  P_C, REG_WR, DIR_WRA, DI_banco,
    output tx, busy, fifo_count, overflow, drop_count
  );
endinterface

// File: rtl/wb_trace_uart.sv
// Write-back trace observer: buffers {PC, rd, data} records in a small FIFO and
// streams each record as a 7-byte 8N1 UART frame. It never stalls the core.
module wb_trace_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input logic            reloj,
  input logic            reset,
  wb_trace_uart_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int REC_W  = 43;
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        dropCount_q, dropCount_d;
  state_e            state_q, state_d;
  logic [REC_W-1:0]  frame_q, frame_d;
  logic [2:0]        byteIdx_q, byteIdx_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              tx_q, tx_d;
  logic              pop;
  logic              pushAccept;
  logic              fifoEmpty;
  logic              baudDone;
  logic [7:0]        txByte;

  function automatic logic [7:0] frameByte(input logic [REC_W-1:0] rec, input logic [2:0] idx);
    case (idx)
      3'd0:    frameByte = 8'hA5;
      3'd1:    frameByte = {2'b00, rec[42:37]};
      3'd2:    frameByte = {3'b000, rec[36:32]};
      3'd3:    frameByte = rec[31:24];
      3'd4:    frameByte = rec[23:16];
      3'd5:    frameByte = rec[15:8];
      default: frameByte = rec[7:0];
    endcase
  endfunction

  assign fifoEmpty = (count_q == '0);
  assign baudDone  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    byteIdx_d = byteIdx_q;
    bitIdx_d  = bitIdx_q;
    baud_d    = baud_q;
    pop       = 1'b0;
    tx_d      = 1'b1;

    if (state_q != IDLE) begin
      baud_d = baudDone ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baudDone) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (baudDone) begin
          if (bitIdx_q == 3'd7) state_d = STOP;
          else                  bitIdx_d = bitIdx_q + 1'b1;
        end
      end
      STOP: begin
        // After the last byte, chain straight into the next frame if one is waiting
        if (baudDone) begin
          if (byteIdx_q != 3'd6) begin
            byteIdx_d = byteIdx_q + 1'b1;
            state_d   = START;
          end else if (!fifoEmpty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      frame_d   = mem_q[rdPtr_q];
      byteIdx_d = '0;
      baud_d    = '0;
    end

    // tx is computed from next-state values so the registered line changes on the transition edge
    txByte = frameByte(frame_d, byteIdx_d);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = txByte[bitIdx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    pushAccept  = bus.REG_WR && ((count_q != FULL) || pop);
    wrPtr_d     = pushAccept ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d     = pop ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    dropCount_d = dropCount_q;

    if (pushAccept && !pop)      count_d = count_q + 1'b1;
    else if (!pushAccept && pop) count_d = count_q - 1'b1;

    if (bus.REG_WR && !pushAccept) begin
      overflow_d = 1'b1;
      if (dropCount_q != 8'hFF) dropCount_d = dropCount_q + 1'b1;
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      byteIdx_q   <= '0;
      bitIdx_q    <= '0;
      baud_q      <= '0;
      tx_q        <= 1'b1;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      dropCount_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      byteIdx_q   <= byteIdx_d;
      bitIdx_q    <= bitIdx_d;
      baud_q      <= baud_d;
      tx_q        <= tx_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      dropCount_q <= dropCount_d;
    end
  end

  // Storage needs no reset; the pointers and count decide what is valid
  always_ff @(posedge reloj) begin
    if (pushAccept && !reset) begin
      mem_q[wrPtr_q] <= {bus.P_C, bus.DIR_WRA, bus.DI_banco};
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = dropCount_q;
endmodule

// File: tb/tb_wb_trace_uart.sv
// Bench for wb_trace_uart: a time-based reference model predicts every output each
// cycle, and a UART decoder recovers the byte stream for frame-level checks.
module tb_wb_trace_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int FRAME = 7 * BYTE_CYC;

  logic reloj = 1'b0;
  logic reset = 1'b0;
  always #5 reloj = ~reloj;

  wb_trace_uart_if #(.FIFO_DEPTH(DEPTH)) bus ();

  wb_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [5:0]  pc;
    logic [4:0]  rd;
    logic [31:0] data;
    int          expCount;
    logic        expBusy;
    logic        expOvf;
    int          expDrop;
  } vec_t;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;

  // Reference model: a record queue plus the number of cycles left in the frame on the wire
  logic [42:0] mq [$];
  int          frameLeft = 0;
  logic [7:0]  curFrame [7];
  logic        mOvf = 1'b0;
  int          mDrop = 0;
  logic [7:0]  expBytes [$];

  logic [7:0]  gotBytes [$];
  int          gotStart [$];
  int          framingErr = 0;

  always @(posedge reloj) cyc <= cyc + 1;

  function automatic logic [7:0] frameByte(input logic [42:0] r, input int k);
    case (k)
      0:       return 8'hA5;
      1:       return {2'b00, r[42:37]};
      2:       return {3'b000, r[36:32]};
      3:       return r[31:24];
      4:       return r[23:16];
      5:       return r[15:8];
      default: return r[7:0];
    endcase
  endfunction

  function automatic logic modelTx();
    int elapsed, k, b;
    if (frameLeft == 0) return 1'b1;
    elapsed = FRAME - frameLeft;
    k = elapsed / BYTE_CYC;
    b = (elapsed % BYTE_CYC) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return curFrame[k][b-1];
  endfunction

  task automatic modelStep(input logic rst, input logic wr, input logic [42:0] rec);
    int   sizeBefore;
    logic popped;
    logic [42:0] head;
    if (rst) begin
      mq.delete();
      frameLeft = 0;
      mOvf = 1'b0;
      mDrop = 0;
      return;
    end
    sizeBefore = mq.size();
    popped = 1'b0;
    if (frameLeft > 0) frameLeft--;
    if (frameLeft == 0 && sizeBefore > 0) begin
      head = mq.pop_front();
      for (int k = 0; k < 7; k++) begin
        curFrame[k] = frameByte(head, k);
        expBytes.push_back(curFrame[k]);
      end
      frameLeft = FRAME;
      popped = 1'b1;
    end
    if (wr) begin
      if (sizeBefore < DEPTH || popped) begin
        mq.push_back(rec);
      end else begin
        mOvf = 1'b1;
        if (mDrop < 255) mDrop++;
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    checkVal("tx", 32'(bus.tx), 32'(modelTx()));
    checkVal("busy", 32'(bus.busy), 32'(frameLeft > 0));
    checkVal("fifo_count", 32'(bus.fifo_count), mq.size());
    checkVal("overflow", 32'(bus.overflow), 32'(mOvf));
    checkVal("drop_count", 32'(bus.drop_count), mDrop);
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [5:0] pc,
                               input logic [4:0] rd, input logic [31:0] data);
    reset        = rst;
    bus.REG_WR   = wr;
    bus.P_C      = pc;
    bus.DIR_WRA  = rd;
    bus.DI_banco = data;
    modelStep(rst, wr, {pc, rd, data});
    @(negedge reloj);
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 6'($urandom), 5'($urandom), $urandom);
  endtask

  task automatic flushMon();
    gotBytes.delete();
    gotStart.delete();
    expBytes.delete();
    framingErr = 0;
  endtask

  task automatic restart();
    applyStimulus(1'b1, 1'b0, 6'd0, 5'd0, 32'd0);
    idle(60);
    flushMon();
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    while ((bus.busy !== 1'b0 || bus.fifo_count != 0) && n < limit) begin
      idle(1);
      n++;
    end
    checkVal({name, "_drainInTime"}, 32'(n < limit), 32'd1);
    idle(2);
  endtask

  task automatic compareStreams(input string name);
    int n;
    checkVal({name, "_byteCount"}, gotBytes.size(), expBytes.size());
    n = (gotBytes.size() < expBytes.size()) ? gotBytes.size() : expBytes.size();
    for (int i = 0; i < n; i++) begin
      checkVal($sformatf("%s_byte%0d", name, i), 32'(gotBytes[i]), 32'(expBytes[i]));
    end
    checkVal({name, "_framing"}, framingErr, 0);
  endtask

  // UART decoder: samples each bit in its middle, on falling clock edges
  initial begin
    int   startCyc;
    logic [7:0] b;
    forever begin
      @(negedge reloj);
      if (bus.tx === 1'b0) begin
        startCyc = cyc;
        repeat (CPB / 2) @(negedge reloj);
        if (bus.tx !== 1'b0) framingErr++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge reloj);
          b[i] = bus.tx;
        end
        repeat (CPB) @(negedge reloj);
        if (bus.tx !== 1'b1) framingErr++;
        gotBytes.push_back(b);
        gotStart.push_back(startCyc);
      end
    end
  end

  initial begin
    vec_t       ovfVecs [7];
    logic [7:0] goldSingle [7];
    logic [7:0] goldAfterReset [7];
    int         n;
    int         peak;

    ovfVecs[0] = '{1'b1, 6'h08, 5'd1, 32'hA000_0001, 1, 1'b0, 1'b0, 0};
    ovfVecs[1] = '{1'b1, 6'h09, 5'd2, 32'hA000_0002, 1, 1'b1, 1'b0, 0};
    ovfVecs[2] = '{1'b1, 6'h0A, 5'd3, 32'hA000_0003, 2, 1'b1, 1'b0, 0};
    ovfVecs[3] = '{1'b1, 6'h0B, 5'd4, 32'hA000_0004, 3, 1'b1, 1'b0, 0};
    ovfVecs[4] = '{1'b1, 6'h0C, 5'd5, 32'hA000_0005, 4, 1'b1, 1'b0, 0};
    ovfVecs[5] = '{1'b1, 6'h0D, 5'd6, 32'hA000_0006, 4, 1'b1, 1'b1, 1};
    ovfVecs[6] = '{1'b1, 6'h0E, 5'd7, 32'hA000_0007, 4, 1'b1, 1'b1, 2};
    goldSingle     = '{8'hA5, 8'h05, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    goldAfterReset = '{8'hA5, 8'h2A, 8'h07, 8'h12, 8'h34, 8'h56, 8'h78};

    bus.REG_WR = 1'b0;
    bus.P_C = '0;
    bus.DIR_WRA = '0;
    bus.DI_banco = '0;
    @(negedge reloj);

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b0, 6'd0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 6'd0, 5'd0, 32'd0);
    checkVal("rst_tx", 32'(bus.tx), 32'd1);
    checkVal("rst_busy", 32'(bus.busy), 32'd0);
    checkVal("rst_count", 32'(bus.fifo_count), 32'd0);
    checkVal("rst_overflow", 32'(bus.overflow), 32'd0);
    checkVal("rst_drop", 32'(bus.drop_count), 32'd0);
    idle(5);
    flushMon();

    $display("[TB] single write");
    applyStimulus(1'b0, 1'b1, 6'h05, 5'd3, 32'hDEAD_BEEF);
    checkVal("single_countAfterPush", 32'(bus.fifo_count), 32'd1);
    checkVal("single_txAfterPush", 32'(bus.tx), 32'd1);
    idle(1);
    checkVal("single_txLowNextCycle", 32'(bus.tx), 32'd0);
    checkVal("single_busyNextCycle", 32'(bus.busy), 32'd1);
    n = 1;
    while (bus.busy === 1'b1 && n < 400) begin
      idle(1);
      if (bus.busy === 1'b1) n++;
    end
    checkVal("single_busyCycles", n, 280);
    checkVal("single_txEnd", 32'(bus.tx), 32'd1);
    checkVal("single_countEnd", 32'(bus.fifo_count), 32'd0);
    checkVal("single_decodedCount", gotBytes.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < gotBytes.size()) checkVal($sformatf("single_byte%0d", i), 32'(gotBytes[i]), 32'(goldSingle[i]));
    end
    checkVal("single_framing", framingErr, 0);

    $display("[TB] idle core");
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      idle(1);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_count != 0) n++;
    end
    checkVal("idle_badCycles", n, 0);

    $display("[TB] burst of four");
    restart();
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 6'(16 + i), 5'(i + 1), 32'(i + 1));
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    end
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    end
    checkVal("burst_peakCount", peak, 3);
    waitIdle("burst", 2000);
    compareStreams("burst");
    for (int f = 0; f < 4; f++) begin
      if (7 * f + 6 < gotBytes.size()) checkVal($sformatf("burst_order%0d", f), 32'(gotBytes[7*f+6]), f + 1);
    end
    for (int i = 1; i < gotStart.size(); i++) begin
      checkVal($sformatf("burst_gap%0d", i), gotStart[i] - gotStart[i-1], BYTE_CYC);
    end
    checkVal("burst_overflow", 32'(bus.overflow), 32'd0);

    $display("[TB] overflow table");
    restart();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, ovfVecs[i].wr, ovfVecs[i].pc, ovfVecs[i].rd, ovfVecs[i].data);
      checkVal($sformatf("ovf_count%0d", i), 32'(bus.fifo_count), ovfVecs[i].expCount);
      checkVal($sformatf("ovf_busy%0d", i), 32'(bus.busy), 32'(ovfVecs[i].expBusy));
      checkVal($sformatf("ovf_flag%0d", i), 32'(bus.overflow), 32'(ovfVecs[i].expOvf));
      checkVal($sformatf("ovf_drop%0d", i), 32'(bus.drop_count), ovfVecs[i].expDrop);
    end
    waitIdle("ovf", 2000);
    compareStreams("ovf");
    checkVal("ovf_framesSent", gotBytes.size(), 35);
    for (int f = 0; f < 5; f++) begin
      if (7 * f + 6 < gotBytes.size()) checkVal($sformatf("ovf_frame%0d", f), 32'(gotBytes[7*f+6]), f + 1);
    end
    idle(200);
    checkVal("ovf_heldFlag", 32'(bus.overflow), 32'd1);
    checkVal("ovf_heldDrop", 32'(bus.drop_count), 32'd2);
    applyStimulus(1'b1, 1'b0, 6'd0, 5'd0, 32'd0);
    checkVal("ovf_flagCleared", 32'(bus.overflow), 32'd0);
    checkVal("ovf_dropCleared", 32'(bus.drop_count), 32'd0);

    $display("[TB] full fifo with simultaneous pop and push");
    restart();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 6'(32 + i), 5'(i), 32'hB000_0000 + 32'(i));
    n = 0;
    while (frameLeft != 1 && n < 400) begin
      idle(1);
      n++;
    end
    checkVal("full_reachedPop", 32'(n < 400), 32'd1);
    checkVal("full_countBeforePop", 32'(bus.fifo_count), 32'd4);
    applyStimulus(1'b0, 1'b1, 6'h3F, 5'd31, 32'hCAFE_F00D);
    checkVal("full_countAfterPopPush", 32'(bus.fifo_count), 32'd4);
    checkVal("full_dropUnchanged", 32'(bus.drop_count), 32'd0);
    checkVal("full_overflowClear", 32'(bus.overflow), 32'd0);
    waitIdle("full", 3000);
    compareStreams("full");
    checkVal("full_framesSent", gotBytes.size(), 42);

    $display("[TB] reset mid-frame");
    restart();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 6'(48 + i), 5'(i), 32'hC000_0000 + 32'(i));
    idle(3 * BYTE_CYC + 10);
    applyStimulus(1'b1, 1'b1, 6'h11, 5'd9, 32'h5555_AAAA);
    checkVal("midrst_tx", 32'(bus.tx), 32'd1);
    checkVal("midrst_busy", 32'(bus.busy), 32'd0);
    checkVal("midrst_count", 32'(bus.fifo_count), 32'd0);
    checkVal("midrst_overflow", 32'(bus.overflow), 32'd0);
    idle(60);
    flushMon();
    applyStimulus(1'b0, 1'b1, 6'h2A, 5'd7, 32'h1234_5678);
    waitIdle("midrst", 1000);
    checkVal("midrst_decodedCount", gotBytes.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < gotBytes.size()) checkVal($sformatf("midrst_byte%0d", i), 32'(gotBytes[i]), 32'(goldAfterReset[i]));
    end
    checkVal("midrst_framing", framingErr, 0);

    $display("[TB] random traffic");
    restart();
    for (int i = 0; i < 3000; i++) begin
      int pct;
      pct = ((i / 500) % 2 == 0) ? 40 : 2;
      applyStimulus(1'b0, 1'($urandom_range(99) < pct), 6'($urandom), 5'($urandom), $urandom);
    end
    waitIdle("random", 3000);
    compareStreams("random");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
